// File: rtl/sirius_fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package sirius_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } fetch_state_t;

    localparam int FETCH_BYTES = 8;
    localparam int INST_W      = 32;
    // Address bit selecting the upper word of an aligned fetch block.
    localparam int HALF_BIT    = $clog2(FETCH_BYTES) - 1;

endpackage

// File: rtl/fetch_sat_cnt.sv
// Saturating event counter: increments on inc, holds at all-ones, clears on rst.
module fetch_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: one outstanding I-cache request, pushes returned
// instructions into the inst FIFO and discards responses made stale by redirects.
module fetch_ctrl
    import sirius_fetch_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_address,
    input  logic             redirect,
    input  logic             fifo_full,
    output logic             pc_en,
    output logic             inst_ok_1,
    output logic             inst_ok_2,
    output logic             pc_stall,
    output logic             ic_req,
    output logic [31:0]      ic_addr,
    input  logic             ic_addr_ok,
    input  logic             ic_data_ok,
    input  logic [63:0]      ic_rdata,
    output logic             fifo_push,
    output logic [1:0]       fifo_cnt,
    output logic [31:0]      fifo_inst0,
    output logic [31:0]      fifo_inst1,
    output logic [31:0]      fifo_pc0,
    output logic [CNT_W-1:0] stat_fetch,
    output logic [CNT_W-1:0] stat_drop
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  req_pc_q;
    logic [31:0]  req_pc_d;
    logic         push;
    logic         drop;
    logic         odd_half;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        req_pc_q <= req_pc_d;
    end

    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        push     = 1'b0;
        drop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // FIFO space for a whole fetch is reserved here, before issuing.
                if (!redirect && !fifo_full) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ic_addr_ok) begin
                    req_pc_d = pc_address;
                    state_d  = redirect ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (ic_data_ok) begin
                    state_d = IDLE;
                    if (redirect) begin
                        drop = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (ic_data_ok) begin
                    drop    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            push = 1'b0;
            drop = 1'b0;
        end
    end

    // An odd-word PC only consumes the upper half of the returned block.
    assign odd_half = req_pc_q[HALF_BIT];

    always_comb begin
        ic_req     = !rst && (state_q == REQ);
        ic_addr    = ic_req ? {pc_address[31:2], 2'b00} : 32'd0;
        pc_en      = !rst && (redirect || push);
        pc_stall   = !rst && !push && fifo_full;
        fifo_push  = push;
        inst_ok_1  = push;
        inst_ok_2  = push && !odd_half;
        fifo_cnt   = 2'd0;
        fifo_inst0 = 32'd0;
        fifo_inst1 = 32'd0;
        fifo_pc0   = 32'd0;
        if (push) begin
            fifo_pc0 = req_pc_q;
            if (odd_half) begin
                fifo_cnt   = 2'd1;
                fifo_inst0 = ic_rdata[2*INST_W-1:INST_W];
            end else begin
                fifo_cnt   = 2'd2;
                fifo_inst0 = ic_rdata[INST_W-1:0];
                fifo_inst1 = ic_rdata[2*INST_W-1:INST_W];
            end
        end
    end

    fetch_sat_cnt #(.CNT_W(CNT_W)) u_fetch_cnt (
        .clk (clk),
        .rst (rst),
        .inc (push),
        .cnt (stat_fetch)
    );

    fetch_sat_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk (clk),
        .rst (rst),
        .inc (drop),
        .cnt (stat_drop)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: per-cycle comparison against a transaction-level
// model, plus literal expectations at the key points of each scenario.
module tb_fetch_ctrl;

    localparam int CNT_W = 2;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic [31:0]      pc_address;
    logic             redirect;
    logic             fifo_full;
    logic             pc_en;
    logic             inst_ok_1;
    logic             inst_ok_2;
    logic             pc_stall;
    logic             ic_req;
    logic [31:0]      ic_addr;
    logic             ic_addr_ok;
    logic             ic_data_ok;
    logic [63:0]      ic_rdata;
    logic             fifo_push;
    logic [1:0]       fifo_cnt;
    logic [31:0]      fifo_inst0;
    logic [31:0]      fifo_inst1;
    logic [31:0]      fifo_pc0;
    logic [CNT_W-1:0] stat_fetch;
    logic [CNT_W-1:0] stat_drop;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    fetch_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_address (pc_address),
        .redirect   (redirect),
        .fifo_full  (fifo_full),
        .pc_en      (pc_en),
        .inst_ok_1  (inst_ok_1),
        .inst_ok_2  (inst_ok_2),
        .pc_stall   (pc_stall),
        .ic_req     (ic_req),
        .ic_addr    (ic_addr),
        .ic_addr_ok (ic_addr_ok),
        .ic_data_ok (ic_data_ok),
        .ic_rdata   (ic_rdata),
        .fifo_push  (fifo_push),
        .fifo_cnt   (fifo_cnt),
        .fifo_inst0 (fifo_inst0),
        .fifo_inst1 (fifo_inst1),
        .fifo_pc0   (fifo_pc0),
        .stat_fetch (stat_fetch),
        .stat_drop  (stat_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string nm);
        for (int i = 0; i < 16 && !ic_req; i++) tick();
        n_vec++;
        if (!ic_req) begin
            n_err++;
            $display("FAIL %s: ic_req got 0 after 16 cycles, expected 1", nm);
        end
    endtask

    // Model state: a request is being offered, one is outstanding, and whether
    // the outstanding one has been made stale by a redirect.
    bit          m_req = 0;
    bit          m_out = 0;
    bit          m_stale = 0;
    logic [31:0] m_pc = 32'd0;
    int          m_fetch = 0;
    int          m_drop = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            bit          e_push;
            bit          e_drop;
            bit          odd;
            logic [1:0]  e_cnt;
            logic [31:0] e_i0;
            logic [31:0] e_i1;
            e_push = !rst && m_out && !m_stale && ic_data_ok && !redirect;
            e_drop = !rst && m_out && ic_data_ok && (m_stale || redirect);
            odd    = m_pc[2];
            e_cnt  = !e_push ? 2'd0 : (odd ? 2'd1 : 2'd2);
            e_i0   = !e_push ? 32'd0 : (odd ? ic_rdata[63:32] : ic_rdata[31:0]);
            e_i1   = (e_push && !odd) ? ic_rdata[63:32] : 32'd0;

            chk("ic_req",     64'(ic_req),     64'(!rst && m_req));
            chk("ic_addr",    64'(ic_addr),    64'((!rst && m_req) ? (pc_address & ~32'd3) : 32'd0));
            chk("pc_en",      64'(pc_en),      64'(!rst && (redirect || e_push)));
            chk("pc_stall",   64'(pc_stall),   64'(!rst && !e_push && fifo_full));
            chk("fifo_push",  64'(fifo_push),  64'(e_push));
            chk("inst_ok_1",  64'(inst_ok_1),  64'(e_push));
            chk("inst_ok_2",  64'(inst_ok_2),  64'(e_push && !odd));
            chk("fifo_cnt",   64'(fifo_cnt),   64'(e_cnt));
            chk("fifo_inst0", 64'(fifo_inst0), 64'(e_i0));
            chk("fifo_inst1", 64'(fifo_inst1), 64'(e_i1));
            chk("fifo_pc0",   64'(fifo_pc0),   64'(e_push ? m_pc : 32'd0));
            chk("stat_fetch", 64'(stat_fetch), 64'(m_fetch));
            chk("stat_drop",  64'(stat_drop),  64'(m_drop));

            if (rst) begin
                m_req = 0; m_out = 0; m_stale = 0; m_fetch = 0; m_drop = 0;
            end else begin
                if (e_push && m_fetch < SAT) m_fetch++;
                if (e_drop && m_drop < SAT) m_drop++;
                if (m_out) begin
                    if (ic_data_ok) begin
                        m_out = 0;
                        m_stale = 0;
                    end else if (redirect) begin
                        m_stale = 1;
                    end
                end else if (m_req) begin
                    if (ic_addr_ok) begin
                        m_req = 0;
                        m_out = 1;
                        m_stale = redirect;
                        m_pc = pc_address;
                    end
                end else begin
                    m_req = !redirect && !fifo_full;
                end
            end
        end
    end

    initial begin
        rst = 1'b1; pc_address = 32'hbfc0_0000; redirect = 1'b0; fifo_full = 1'b0;
        ic_addr_ok = 1'b0; ic_data_ok = 1'b0; ic_rdata = 64'd0;

        // Reset
        tick(); chk_en = 1;
        @(negedge clk);
        chk("rst ic_req", 64'(ic_req), 64'd0);
        chk("rst pc_en", 64'(pc_en), 64'd0);
        tick();
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("idle ic_req", 64'(ic_req), 64'd0);
        chk("idle stat_fetch", 64'(stat_fetch), 64'd0);
        tick(); ic_addr_ok = 1'b1;
        @(negedge clk);
        chk("first ic_req", 64'(ic_req), 64'd1);
        chk("first ic_addr", 64'(ic_addr), 64'hbfc0_0000);

        // Aligned fetch
        tick(); ic_addr_ok = 1'b0;
        @(negedge clk);
        chk("wait no push", 64'(fifo_push), 64'd0);
        tick(); ic_data_ok = 1'b1; ic_rdata = {32'hbbbb_0001, 32'haaaa_0000};
        @(negedge clk);
        chk("al push", 64'(fifo_push), 64'd1);
        chk("al cnt", 64'(fifo_cnt), 64'd2);
        chk("al inst0", 64'(fifo_inst0), 64'haaaa_0000);
        chk("al inst1", 64'(fifo_inst1), 64'hbbbb_0001);
        chk("al ok2", 64'(inst_ok_2), 64'd1);
        chk("al pc_en", 64'(pc_en), 64'd1);
        chk("al pc0", 64'(fifo_pc0), 64'hbfc0_0000);

        // Odd-word fetch
        tick(); ic_data_ok = 1'b0; pc_address = 32'hbfc0_0004;
        @(negedge clk);
        chk("al stat_fetch", 64'(stat_fetch), 64'd1);
        tick(); ic_addr_ok = 1'b1;
        @(negedge clk);
        chk("odd ic_addr", 64'(ic_addr), 64'hbfc0_0004);
        tick(); ic_addr_ok = 1'b0; ic_data_ok = 1'b1; ic_rdata = {32'hcccc_0003, 32'hdddd_0002};
        @(negedge clk);
        chk("odd cnt", 64'(fifo_cnt), 64'd1);
        chk("odd inst0", 64'(fifo_inst0), 64'hcccc_0003);
        chk("odd ok2", 64'(inst_ok_2), 64'd0);
        chk("odd pc_en", 64'(pc_en), 64'd1);

        // Redirect while waiting for data
        tick(); ic_data_ok = 1'b0; pc_address = 32'hbfc0_0008;
        tick(); ic_addr_ok = 1'b1;
        tick(); ic_addr_ok = 1'b0; redirect = 1'b1;
        @(negedge clk);
        chk("rw pc_en", 64'(pc_en), 64'd1);
        tick(); redirect = 1'b0; pc_address = 32'hbfc0_0100;
        tick(); ic_data_ok = 1'b1; ic_rdata = 64'h1234_5678_9abc_def0;
        @(negedge clk);
        chk("rw stale push", 64'(fifo_push), 64'd0);
        tick(); ic_data_ok = 1'b0;
        @(negedge clk);
        chk("rw stat_drop", 64'(stat_drop), 64'd1);
        tick(); ic_addr_ok = 1'b1;
        @(negedge clk);
        chk("rw new addr", 64'(ic_addr), 64'hbfc0_0100);

        // Redirect in the same cycle as data return
        tick(); ic_addr_ok = 1'b0; ic_data_ok = 1'b1; redirect = 1'b1;
        @(negedge clk);
        chk("rd push", 64'(fifo_push), 64'd0);
        chk("rd ok1", 64'(inst_ok_1), 64'd0);
        chk("rd pc_en", 64'(pc_en), 64'd1);

        // FIFO full held in IDLE
        tick(); ic_data_ok = 1'b0; redirect = 1'b0; fifo_full = 1'b1;
        @(negedge clk);
        chk("rd stat_drop", 64'(stat_drop), 64'd2);
        chk("ff pc_stall", 64'(pc_stall), 64'd1);
        chk("ff pc_en", 64'(pc_en), 64'd0);
        repeat (2) tick();
        @(negedge clk);
        chk("ff no req", 64'(ic_req), 64'd0);
        tick(); fifo_full = 1'b0;
        tick();
        @(negedge clk);
        chk("ff release req", 64'(ic_req), 64'd1);

        // Redirect in REQ: address follows PC, then accept with redirect -> drop
        tick(); redirect = 1'b1; pc_address = 32'hbfc0_0203;
        @(negedge clk);
        chk("rq addr follow", 64'(ic_addr), 64'hbfc0_0200);
        tick(); ic_addr_ok = 1'b1;
        tick(); ic_addr_ok = 1'b0; redirect = 1'b0; ic_data_ok = 1'b1;
        tick(); pc_address = 32'hbfc0_0300;
        @(negedge clk);
        chk("idle data ignored", 64'(fifo_push), 64'd0);
        chk("rq stat_drop", 64'(stat_drop), 64'd3);
        tick(); ic_data_ok = 1'b0; ic_addr_ok = 1'b1; redirect = 1'b1;
        tick(); ic_addr_ok = 1'b0; redirect = 1'b0; ic_data_ok = 1'b1;
        tick(); ic_data_ok = 1'b0;
        @(negedge clk);
        chk("drop saturated", 64'(stat_drop), 64'd3);

        // Reset in the middle of a fetch
        tick(); ic_addr_ok = 1'b1;
        tick(); ic_addr_ok = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("mid rst pc_en", 64'(pc_en), 64'd0);
        tick(); rst = 1'b0; ic_data_ok = 1'b1;
        @(negedge clk);
        chk("post rst push", 64'(fifo_push), 64'd0);
        chk("post rst drop", 64'(stat_drop), 64'd0);
        tick(); ic_data_ok = 1'b0;

        // Back-to-back fetches with varied latency; fetch counter saturates
        for (int k = 0; k < 5; k++) begin
            wait_req("loop req");
            pc_address = 32'h8000_0000 + 32'(k * 4);
            ic_addr_ok = 1'b1;
            tick(); ic_addr_ok = 1'b0;
            repeat (k % 3) tick();
            ic_data_ok = 1'b1;
            ic_rdata = {32'h5000_0000 + 32'(k), 32'h4000_0000 + 32'(k)};
            tick(); ic_data_ok = 1'b0;
        end
        @(negedge clk);
        chk("fetch saturated", 64'(stat_fetch), 64'd3);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
